// File: rtl/mmcm_phase_step_ctrl.sv
// Fine-phase-shift sequencer for the MMCM dynamic phase-shift port.
// Issues one PSEN per requested step, tracks the absolute tap offset, and enforces position limits and a PSDONE timeout.
`timescale 1ns/1ps
module mmcm_phase_step_ctrl #(
  parameter int CNT_W          = 8,
  parameter int POS_W          = 10,
  parameter int POS_MAX        = 448,
  parameter int POS_MIN        = -448,
  parameter int PSDONE_TIMEOUT = 31,
  parameter int SETTLE_CYC     = 4
) (
  input  logic                    clk_bufg,
  input  logic                    rst_tmp,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_incdec,
  input  logic [CNT_W-1:0]        req_steps,
  output logic                    PSEN,
  output logic                    PSINCDEC,
  input  logic                    PSDONE,
  output logic                    busy,
  output logic                    done_pulse,
  output logic [CNT_W-1:0]        steps_done,
  output logic signed [POS_W-1:0] phase_pos,
  output logic                    err_limit,
  output logic                    err_timeout
);

  localparam int TMO_W = $clog2(PSDONE_TIMEOUT + 1);
  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam logic [POS_W-1:0] P_MAX = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] P_MIN = POS_W'(POS_MIN);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, SETTLE, DONE, HALT} state_t;

  state_t                    state, state_nxt;
  logic [CNT_W-1:0]          remaining, rem_nxt, steps_nxt;
  logic [TMO_W-1:0]          tmo_cnt, tmo_nxt;
  logic [SET_W-1:0]          set_cnt, set_nxt;
  logic signed [POS_W-1:0]   pos_nxt;
  logic                      dir_nxt, elim_nxt, etmo_nxt;

  function automatic logic at_limit(input logic inc);
    return inc ? (phase_pos == P_MAX) : (phase_pos == P_MIN);
  endfunction

  always_comb begin
    state_nxt = state;
    rem_nxt   = remaining;
    steps_nxt = steps_done;
    tmo_nxt   = tmo_cnt;
    set_nxt   = set_cnt;
    pos_nxt   = phase_pos;
    dir_nxt   = PSINCDEC;
    elim_nxt  = err_limit;
    etmo_nxt  = err_timeout;
    case (state)
      IDLE: if (req_valid && req_ready) begin
        dir_nxt   = req_incdec;
        rem_nxt   = req_steps;
        steps_nxt = '0;
        elim_nxt  = 1'b0;
        if (req_steps == '0) state_nxt = DONE;
        else if (at_limit(req_incdec)) begin
          elim_nxt  = 1'b1;
          state_nxt = DONE;
        end else state_nxt = ISSUE;
      end
      // tmo_cnt holds cycles elapsed since the PSEN cycle
      ISSUE: begin
        tmo_nxt   = TMO_W'(1);
        state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (PSDONE) begin
          pos_nxt   = PSINCDEC ? phase_pos + POS_W'(1) : phase_pos - POS_W'(1);
          steps_nxt = steps_done + CNT_W'(1);
          rem_nxt   = remaining - CNT_W'(1);
          set_nxt   = '0;
          state_nxt = (remaining == CNT_W'(1)) ? DONE : SETTLE;
        end else if (tmo_cnt == TMO_W'(PSDONE_TIMEOUT - 1)) begin
          etmo_nxt  = 1'b1;
          state_nxt = HALT;
        end else tmo_nxt = tmo_cnt + TMO_W'(1);
      end
      SETTLE: begin
        if (set_cnt == SET_W'(SETTLE_CYC - 1)) begin
          if (at_limit(PSINCDEC)) begin
            elim_nxt  = 1'b1;
            state_nxt = DONE;
          end else state_nxt = ISSUE;
        end else set_nxt = set_cnt + SET_W'(1);
      end
      DONE:    state_nxt = IDLE;
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with it.
  always_ff @(posedge clk_bufg or posedge rst_tmp) begin
    if (rst_tmp) begin
      state       <= IDLE;
      remaining   <= '0;
      tmo_cnt     <= '0;
      set_cnt     <= '0;
      steps_done  <= '0;
      phase_pos   <= '0;
      PSINCDEC    <= 1'b0;
      PSEN        <= 1'b0;
      req_ready   <= 1'b0;
      busy        <= 1'b0;
      done_pulse  <= 1'b0;
      err_limit   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      remaining   <= rem_nxt;
      tmo_cnt     <= tmo_nxt;
      set_cnt     <= set_nxt;
      steps_done  <= steps_nxt;
      phase_pos   <= pos_nxt;
      PSINCDEC    <= dir_nxt;
      PSEN        <= (state_nxt == ISSUE);
      req_ready   <= (state_nxt == IDLE);
      busy        <= (state_nxt == ISSUE) || (state_nxt == WAIT_DONE) ||
                     (state_nxt == SETTLE) || (state_nxt == DONE);
      done_pulse  <= (state_nxt == DONE);
      err_limit   <= elim_nxt;
      err_timeout <= etmo_nxt;
    end
  end

endmodule

// File: tb/tb_mmcm_phase_step_ctrl.sv
// Directed bench for mmcm_phase_step_ctrl with a PSDONE responder of programmable latency.
`timescale 1ns/1ps
module tb_mmcm_phase_step_ctrl;
  localparam int CNT_W = 8;
  localparam int POS_W = 10;

  logic clk_bufg = 1'b0, rst_tmp = 1'b1;
  logic req_valid = 1'b0, req_incdec = 1'b0;
  logic [CNT_W-1:0] req_steps = '0;
  logic req_ready, PSEN, PSINCDEC, PSDONE, busy, done_pulse, err_limit, err_timeout;
  logic [CNT_W-1:0] steps_done;
  logic signed [POS_W-1:0] phase_pos;
  logic psdone_model = 1'b0, psdone_man = 1'b0;
  assign PSDONE = psdone_model | psdone_man;

  mmcm_phase_step_ctrl dut (
    .clk_bufg(clk_bufg), .rst_tmp(rst_tmp), .req_valid(req_valid), .req_ready(req_ready),
    .req_incdec(req_incdec), .req_steps(req_steps), .PSEN(PSEN), .PSINCDEC(PSINCDEC),
    .PSDONE(PSDONE), .busy(busy), .done_pulse(done_pulse), .steps_done(steps_done),
    .phase_pos(phase_pos), .err_limit(err_limit), .err_timeout(err_timeout)
  );

  always #5 clk_bufg = ~clk_bufg;

  int checks = 0, errors = 0;
  int cyc = 0, done_n = 0, done_cyc = -1, tmo_cyc = -1, pd_cyc = -1;
  int lat = 12, pend = 0;
  logic model_en = 1'b1;
  int psen_q[$];
  logic psen_d[$];
  bit rdy_hist [32768];

  // Monitor and PSDONE responder, sampled 1ns after each rising edge.
  initial forever begin
    @(posedge clk_bufg);
    cyc++;
    #1;
    if (PSEN) begin psen_q.push_back(cyc); psen_d.push_back(PSINCDEC); end
    if (done_pulse) begin done_n++; done_cyc = cyc; end
    if (err_timeout && tmo_cyc < 0) tmo_cyc = cyc;
    if (cyc < 32768) rdy_hist[cyc] = req_ready;
    psdone_model = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin psdone_model = 1'b1; pd_cyc = cyc; end
    end
    if (PSEN && model_en) pend = lat;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int q_at(input int i);
    return (i < psen_q.size()) ? psen_q[i] : -1;
  endfunction

  function automatic int count_dir(input int base, input logic v);
    int n = 0;
    for (int i = base; i < psen_d.size(); i++) if (psen_d[i] == v) n++;
    return n;
  endfunction

  task automatic issue(input logic inc, input int steps, output int acc);
    int n = 0;
    @(negedge clk_bufg);
    req_valid = 1'b1; req_incdec = inc; req_steps = steps[CNT_W-1:0];
    while (!req_ready && n < 100) begin @(negedge clk_bufg); n++; end
    chk("req_accept", req_ready, 1);
    acc = cyc;
    @(negedge clk_bufg);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int base, input int budget);
    int n = 0;
    while (done_n == base && n < budget) begin @(negedge clk_bufg); n++; end
    chk(tag, done_n - base, 1);
    repeat (2) @(negedge clk_bufg);
  endtask

  task automatic wait_cyc(input int target);
    int n = 0;
    while (cyc < target && n < 1000) begin @(negedge clk_bufg); n++; end
  endtask

  initial begin
    int acc, pb, db, lows;
    repeat (3) @(negedge clk_bufg);
    chk("rst_ready", req_ready, 0);
    chk("rst_flags", {PSEN, busy, done_pulse, err_limit, err_timeout}, 0);
    chk("rst_pos_steps", {phase_pos, steps_done}, 0);
    rst_tmp = 1'b0;
    @(negedge clk_bufg);
    chk("idle_ready", req_ready, 1);

    // Test 1: inc 3, PSDONE after 12 cycles
    pb = psen_q.size(); db = done_n;
    issue(1'b1, 3, acc);
    wait_done("t1_done", db, 200);
    chk("t1_npsen", psen_q.size() - pb, 3);
    chk("t1_first_psen", q_at(pb), acc + 1);
    chk("t1_gap1", q_at(pb + 1) - q_at(pb), 17);
    chk("t1_gap2", q_at(pb + 2) - q_at(pb + 1), 17);
    chk("t1_dir", count_dir(pb, 1'b1), 3);
    chk("t1_done_cyc", done_cyc, acc + 48);
    chk("t1_pos", $signed(phase_pos), 3);
    chk("t1_steps", steps_done, 3);
    chk("t1_errs", {err_limit, err_timeout}, 0);

    // Test 2: dec 5 from +3
    pb = psen_q.size(); db = done_n;
    issue(1'b0, 5, acc);
    wait_done("t2_done", db, 300);
    chk("t2_npsen", psen_q.size() - pb, 5);
    chk("t2_dir0", count_dir(pb, 1'b0), 5);
    chk("t2_span", q_at(pb + 4) - q_at(pb), 68);
    chk("t2_pos", $signed(phase_pos), -2);
    chk("t2_done_cyc", done_cyc, acc + 82);
    lows = 0;
    for (int c = acc + 1; c <= done_cyc; c++) if (rdy_hist[c]) lows++;
    chk("t2_ready_low", lows, 0);
    chk("t2_ready_back", rdy_hist[done_cyc + 1], 1);

    // Test 5: zero steps and spurious PSDONE in IDLE
    pb = psen_q.size(); db = done_n;
    issue(1'b1, 0, acc);
    wait_done("t5_done", db, 20);
    chk("t5_done_cyc", done_cyc, acc + 1);
    chk("t5_npsen", psen_q.size() - pb, 0);
    chk("t5_pos", $signed(phase_pos), -2);
    @(negedge clk_bufg) psdone_man = 1'b1;
    @(negedge clk_bufg) psdone_man = 1'b0;
    @(negedge clk_bufg);
    chk("t5_spurious_pos", $signed(phase_pos), -2);
    chk("t5_spurious_steps", steps_done, 0);

    // Test 3: preload to 446, then run into POS_MAX
    lat = 2;
    db = done_n; issue(1'b1, 255, acc); wait_done("t3_pre1", db, 2500);
    db = done_n; issue(1'b1, 193, acc); wait_done("t3_pre2", db, 2000);
    chk("t3_preload_pos", $signed(phase_pos), 446);
    pb = psen_q.size(); db = done_n;
    issue(1'b1, 5, acc);
    wait_done("t3_done", db, 200);
    chk("t3_npsen", psen_q.size() - pb, 2);
    chk("t3_pos", $signed(phase_pos), 448);
    chk("t3_steps", steps_done, 2);
    chk("t3_err_limit", err_limit, 1);
    db = done_n;
    issue(1'b0, 1, acc);
    wait_done("t3_dec_done", db, 100);
    chk("t3_err_clr", err_limit, 0);
    chk("t3_dec_pos", $signed(phase_pos), 447);

    // Test 4: PSDONE timeout after first step
    @(negedge clk_bufg) rst_tmp = 1'b1;
    @(negedge clk_bufg) rst_tmp = 1'b0;
    @(negedge clk_bufg);
    chk("t4_pos_reset", $signed(phase_pos), 0);
    lat = 12; model_en = 1'b1;
    pb = psen_q.size();
    issue(1'b1, 4, acc);
    wait_cyc(acc + 14);
    model_en = 1'b0;
    begin
      int n = 0;
      while (tmo_cyc < 0 && n < 200) begin @(negedge clk_bufg); n++; end
    end
    chk("t4_psen2", q_at(pb + 1), acc + 18);
    chk("t4_tmo_cyc", tmo_cyc, acc + 49);
    chk("t4_pos", $signed(phase_pos), 1);
    chk("t4_steps", steps_done, 1);
    chk("t4_halt_ready_busy", {req_ready, busy}, 0);
    req_valid = 1'b1; req_incdec = 1'b1; req_steps = 8'd3;
    repeat (10) @(negedge clk_bufg);
    req_valid = 1'b0;
    chk("t4_halt_npsen", psen_q.size() - pb, 2);
    chk("t4_halt_state", {req_ready, busy, err_timeout}, 1);
    rst_tmp = 1'b1;
    #1;
    chk("t4_rst_all", {req_ready, PSEN, busy, done_pulse, err_limit, err_timeout, steps_done, phase_pos}, 0);

    // Test 6: reset mid-step, late PSDONE ignored
    @(negedge clk_bufg) rst_tmp = 1'b0;
    repeat (2) @(negedge clk_bufg);
    model_en = 1'b1;
    pb = psen_q.size(); db = done_n;
    issue(1'b1, 6, acc);
    wait_cyc(acc + 22);
    chk("t6_npsen", psen_q.size() - pb, 2);
    chk("t6_pos_pre", $signed(phase_pos), 1);
    rst_tmp = 1'b1;
    #1;
    chk("t6_async_pos", $signed(phase_pos), 0);
    chk("t6_async_psen_busy", {PSEN, busy}, 0);
    @(negedge clk_bufg);
    @(negedge clk_bufg) rst_tmp = 1'b0;
    wait_cyc(acc + 35);
    chk("t6_late_pd_cyc", pd_cyc, acc + 30);
    chk("t6_late_pos", $signed(phase_pos), 0);
    chk("t6_late_steps", steps_done, 0);
    chk("t6_no_done", done_n - db, 0);
    db = done_n;
    issue(1'b1, 1, acc);
    wait_done("t6_new_done", db, 100);
    chk("t6_new_pos", $signed(phase_pos), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
